// File: rtl/avalon_multi_timer.sv
// rtl/avalon_multi_timer.sv - NUM_CH-channel prescaled countdown timer on a 32-bit Avalon-MM slave
module avalon_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 124999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

  logic       wr;
  logic [2:0] ch_sel;
  logic [1:0] reg_sel;
  logic [31:0] rd_word [8];

  assign wr      = chipselect & ~write_n;
  assign ch_sel  = address[4:2];
  assign reg_sel = address[1:0];

  // Unimplemented channel slots read as zero and decode no writes.
  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] snap;
      logic [7:0]       prescale;
      logic [7:0]       pcnt;
      logic             ito;
      logic             cont;
      logic             to;
      logic             run;
      logic             reload;
      logic             sel;
      logic             wr_status;
      logic             wr_ctrl;
      logic             wr_period;
      logic             wr_snap;
      logic             start;
      logic             stop;
      logic             tick;
      logic             expire;

      assign sel       = wr && (ch_sel == 3'(i));
      assign wr_status = sel && (reg_sel == 2'd0);
      assign wr_ctrl   = sel && (reg_sel == 2'd1);
      assign wr_period = sel && (reg_sel == 2'd2);
      assign wr_snap   = sel && (reg_sel == 2'd3);
      assign start     = wr_ctrl & writedata[2];
      assign stop      = wr_ctrl & writedata[3];
      // The pending reload owns the counter for its cycle, so no tick is taken then.
      assign tick      = run && !reload && (pcnt == prescale);
      assign expire    = tick && (cnt == '0);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          period   <= RST_VAL;
          cnt      <= RST_VAL;
          snap     <= '0;
          prescale <= 8'd0;
          pcnt     <= 8'd0;
          ito      <= 1'b0;
          cont     <= 1'b0;
          to       <= 1'b0;
          run      <= 1'b0;
          reload   <= 1'b0;
        end else begin
          if (!run || start || tick) pcnt <= 8'd0;
          else                       pcnt <= pcnt + 8'd1;

          if (wr_ctrl) begin
            ito      <= writedata[0];
            cont     <= writedata[1];
            prescale <= writedata[15:8];
          end

          if (wr_period) period <= writedata[CNT_W-1:0];
          reload <= wr_period;

          if (wr_snap) snap <= cnt;

          if (reload || expire) cnt <= period;
          else if (tick)        cnt <= cnt - CNT_W'(1);

          if (wr_status)   to <= 1'b0;
          else if (expire) to <= 1'b1;

          if (reload)              run <= 1'b0;
          else if (start)          run <= 1'b1;
          else if (stop)           run <= 1'b0;
          else if (expire && !cont) run <= 1'b0;
        end
      end

      assign irq_vec[i] = to & ito;
      assign rd_word[i] = (reg_sel == 2'd0) ? {30'b0, run, to} :
                          (reg_sel == 2'd1) ? {16'b0, prescale, 6'b0, cont, ito} :
                          (reg_sel == 2'd2) ? 32'(period) : 32'(snap);
    end else begin : g_off
      assign rd_word[i] = 32'b0;
    end
  end

  assign irq = |irq_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= 32'b0;
    else          readdata <= rd_word[ch_sel];
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// tb/tb_avalon_multi_timer.sv - directed-vector bench for avalon_multi_timer
module tb_avalon_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;
  logic [3:0]  vec_a;
  logic [1:0]  vec_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Both instances share the bus; dut_b has only two channels implemented.
  avalon_multi_timer dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata_a),
    .irq(irq_a), .irq_vec(vec_a)
  );

  avalon_multi_timer #(.NUM_CH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata_b),
    .irq(irq_b), .irq_vec(vec_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus tasks are entered and left on a falling edge.
  task automatic bus_wr(input int ch, input int rg, input logic [31:0] data);
    address    = {3'(ch), 2'(rg)};
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = data;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input int ch, input int rg, output logic [31:0] a, output logic [31:0] b);
    address    = {3'(ch), 2'(rg)};
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    a = rdata_a;
    b = rdata_b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input int idx, input int limit, output int at);
    at = -1000;
    for (int k = 0; k < limit; k++) begin
      if (vec_a[idx]) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [31:0] ra, rb;
  int t0, t1, t2;

  initial begin
    reset_n    = 1'b0;
    address    = 5'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    idle(2);
    check("reset_readdata", rdata_a, 32'd0);
    check("reset_irq", {31'b0, irq_a}, 32'd0);
    check("reset_irq_vec", {28'b0, vec_a}, 32'd0);
    reset_n = 1'b1;
    idle(1);
    bus_rd(0, 2, ra, rb);
    check("reset_period_ch0", ra, 32'd124999);
    bus_rd(0, 0, ra, rb);
    check("reset_status_ch0", ra, 32'd0);

    // Ch1 continuous, PERIOD 9, PRESCALE 0, interrupt enabled
    bus_wr(1, 2, 32'd9);
    idle(1);
    bus_wr(1, 1, 32'h7);
    t0 = cyc;
    wait_rise(1, 30, t1);
    check("ch1_first_timeout_cycles", 32'(t1 - t0), 32'd10);
    check("ch1_irq", {31'b0, irq_a}, 32'd1);
    bus_wr(1, 0, 32'd0);
    check("ch1_status_clear", {31'b0, vec_a[1]}, 32'd0);
    wait_rise(1, 30, t2);
    check("ch1_timeout_interval", 32'(t2 - t1), 32'd10);
    bus_wr(1, 1, 32'h8);

    // Ch2 one-shot, PERIOD 4, PRESCALE 3: timeout 20 cycles after START
    bus_wr(2, 2, 32'd4);
    idle(1);
    bus_wr(2, 1, 32'h0304);
    idle(19);
    bus_rd(2, 0, ra, rb);
    check("ch2_status_before_timeout", ra, 32'h2);
    bus_rd(2, 0, ra, rb);
    check("ch2_status_after_timeout", ra, 32'h1);
    idle(3);
    bus_wr(2, 3, 32'd0);
    bus_rd(2, 3, ra, rb);
    check("ch2_counter_held", ra, 32'd4);

    // Ch0 PERIOD 100 continuous: snapshot after 37 ticks, then PERIOD rewrite
    bus_wr(0, 2, 32'd100);
    idle(1);
    bus_wr(0, 1, 32'h6);
    idle(37);
    bus_wr(0, 3, 32'd0);
    bus_rd(0, 3, ra, rb);
    check("ch0_snap_63", ra, 32'd63);
    bus_rd(0, 1, ra, rb);
    check("ch0_control_read", ra, 32'h2);
    bus_wr(0, 2, 32'd50);
    idle(1);
    bus_rd(0, 0, ra, rb);
    check("ch0_stopped_after_period", ra, 32'h0);
    bus_wr(0, 3, 32'd0);
    bus_rd(0, 3, ra, rb);
    check("ch0_counter_reloaded", ra, 32'd50);
    bus_rd(0, 2, ra, rb);
    check("ch0_period_read", ra, 32'd50);

    // STATUS write on the exact timeout edge, then START|STOP together
    bus_wr(0, 2, 32'd3);
    idle(1);
    bus_wr(0, 1, 32'h7);
    idle(3);
    bus_wr(0, 0, 32'd0);
    check("ch0_clear_wins_irq", {31'b0, vec_a[0]}, 32'd0);
    bus_rd(0, 0, ra, rb);
    check("ch0_clear_wins_status", ra, 32'h2);
    bus_wr(0, 1, 32'h8);
    bus_wr(0, 1, 32'hC);
    bus_rd(0, 0, ra, rb);
    check("ch0_start_stop_run", ra, 32'h2);
    bus_wr(0, 1, 32'h8);

    // Out-of-range channel accesses
    bus_wr(5, 2, 32'd7);
    bus_rd(5, 2, ra, rb);
    check("ch5_read_zero", ra, 32'd0);
    bus_rd(1, 2, ra, rb);
    check("ch1_period_untouched", ra, 32'd9);
    bus_rd(2, 2, ra, rb);
    check("b_ch2_read_zero", rb, 32'd0);
    check("a_ch2_period", ra, 32'd4);

    // dut_b: both channels PERIOD 0, continuous, timing out every cycle
    bus_wr(0, 2, 32'd0);
    bus_wr(1, 2, 32'd0);
    idle(1);
    bus_wr(0, 1, 32'h7);
    bus_wr(1, 1, 32'h7);
    idle(2);
    bus_wr(0, 0, 32'd0);
    check("b_ch0_cleared", {30'b0, vec_b}, 32'h2);
    bus_wr(1, 0, 32'd0);
    check("b_ch1_cleared", {30'b0, vec_b}, 32'h1);
    idle(1);
    check("b_all_timeout", {30'b0, vec_b}, 32'h3);
    check("b_irq", {31'b0, irq_b}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_multi_timer.md
# avalon_multi_timer

Parametrised multi-channel interval timer on a 32-bit Avalon-MM slave, generalising the single-channel system timer to NUM_CH independent countdown channels. Each channel has a programmable counter width, per-channel clock prescaler, one-shot/continuous mode, snapshot and maskable timeout interrupt. It sits on the Nios II data master alongside the existing peripherals and drives a combined irq line plus a per-channel interrupt vector.

## Interface
- NUM_CH, 4, number of channels (1..8)
- CNT_W, 32, counter and period width (8..32)
- RESET_PERIOD, 124999, reset value of every channel's PERIOD and counter (must fit CNT_W)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  5  {channel[2:0], reg[1:0]}
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  OR of all irq_vec bits
- irq_vec  out  NUM_CH  per-channel TO & ITO

## Operation
- Write strobe wr = chipselect & ~write_n. Channel index address[4:2] >= NUM_CH: writes ignored, reads return 0.
- reg 0 STATUS: bit0 TO (timeout latched), bit1 RUN (read-only); any write clears TO.
- reg 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START (write-only pulse), bit3 STOP (write-only pulse), bits[15:8] PRESCALE; read returns {16'b0, PRESCALE, 4'b0, 2'b0, CONT, ITO}.
- reg 2 PERIOD: bits[CNT_W-1:0] stored; upper bits read 0. Writing PERIOD also loads the counter with the new value on the next cycle and stops the channel (RUN=0).
- reg 3 SNAP: any write copies the live counter into SNAP; read returns SNAP, zero-extended.
- Prescaler: per-channel 8-bit counter; while RUN, emits tick when prescale count == PRESCALE, then returns to 0; PRESCALE=0 ticks every cycle. Prescale count clears while RUN=0 and on START.
- Tick with counter != 0: counter decrements by 1.
- Tick with counter == 0: counter <= PERIOD, TO <= 1; if CONT=0, RUN <= 0 (one-shot). Event period = (PERIOD+1)*(PRESCALE+1) cycles.
- START sets RUN without reloading the counter; STOP clears RUN; counter and TO hold while stopped.
- Channels fully independent; simultaneous events on different channels all latch.

## Timing
- Reset values: readdata 0, irq 0, irq_vec 0; per channel counter = PERIOD = RESET_PERIOD, CONTROL 0 (PRESCALE 0), TO 0, RUN 0, SNAP 0.
- Register writes take effect on the clock edge of the write; START/STOP change RUN on that edge.
- PERIOD write: register updates at edge N, counter reloads at edge N+1, RUN=0 from edge N+1; a START in the same cycle as the reload is overridden by the reload stop.
- readdata: address sampled every cycle, valid one cycle after the address is presented (1 read wait-state, read latency 1), independent of chipselect.
- irq_vec/irq: combinational from registered TO and ITO; assert the cycle after the timeout tick edge; deassert the cycle after a STATUS write or ITO clear.
- Simultaneous STATUS write and timeout on same edge: clear wins, TO=0.
- START and STOP both set in one CONTROL write: START wins, RUN=1.
- SNAP write coincident with tick: SNAP captures the pre-tick counter value.
- Counter wrap: never underflows; 0 always reloads PERIOD. PERIOD=0 with CONT=1 and PRESCALE=0: TO set every cycle (level-stable 1).
- Reset asserted mid-count: all state returns to reset values asynchronously; no pending TO survives.

## Test plan
- Reset, read ch0 PERIOD -> 124999 one cycle after address; irq=0, STATUS=0.
- Ch1: PERIOD=9, CONTROL=ITO|CONT|START, PRESCALE=0 -> irq_vec[1] rises every 10 cycles after first tick; STATUS write clears it, re-asserts 10 cycles later.
- Ch2 one-shot: PERIOD=4, PRESCALE=3, START -> TO after 20 cycles, RUN=0, counter=4 and held.
- Ch0 running PERIOD=100: write SNAP after 37 ticks -> SNAP reads 63; PERIOD write mid-count -> RUN=0, counter = new value.
- STATUS write on the exact timeout edge -> TO stays 0; CONTROL write with START|STOP -> RUN=1.
- NUM_CH=2: write address channel 5 -> no state change, read returns 0; all channels timing out simultaneously -> irq_vec=all ones, irq=1.
